// File: rtl/cpu_defs.sv
// Shared definitions for the fetch front end: state encodings, default ROM window,
// and the {pc, ins} entry carried through the fetch queue.
package cpu_defs;

  typedef enum logic [0:0] {
    FETCH_ST_RUN = 1'b0,
    FETCH_ST_ERR = 1'b1
  } fetch_state_e;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
  localparam int unsigned IM_WORDS_DEFAULT = 4096;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries. Flush wins over push; a pop in the
// flush cycle is simply absorbed since the queue ends up empty either way.
module fetch_queue
  import cpu_defs::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  fetch_entry_t      pushData,
  input  logic              pop,
  input  logic              flush,
  output fetch_entry_t      headData,
  output logic [CntW-1:0]   count,
  output logic              full,
  output logic              empty
);

  fetch_entry_t          mem [DEPTH];
  logic [PtrW-1:0]       rdPtr;
  logic [PtrW-1:0]       wrPtr;
  logic                  doPush;
  logic                  doPop;

  // Qualify requests so the FIFO never over- or under-runs on its own.
  always_comb begin
    doPop    = pop && !empty;
    doPush   = push && !flush && (!full || pop);
    full     = (count == CntW'(DEPTH));
    empty    = (count == '0);
    headData = mem[rdPtr];
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PtrW'(1);
      if (doPop)  rdPtr <= rdPtr + PtrW'(1);
      count <= count + CntW'(doPush) - CntW'(doPop);
    end
  end

  // Entry storage; cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (doPush) begin
      mem[wrPtr] <= pushData;
    end
  end

endmodule

// File: rtl/im_fetch_ctrl.sv
// Fetch sequencer for the instruction ROM: owns the fetch PC, queues {pc, ins}
// pairs for decode, handles redirects and traps out-of-window/misaligned PCs.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_stall counters.
module im_fetch_ctrl
  import cpu_defs::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int unsigned IM_WORDS = IM_WORDS_DEFAULT,
  parameter int unsigned FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] im_pc,
  input  logic [31:0] im_ins,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        f_valid,
  output logic [31:0] f_pc,
  output logic [31:0] f_ins,
  output logic        f_err,
  input  logic        dec_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam int unsigned CntW = $clog2(FQ_DEPTH) + 1;
  // One past the last valid byte address; 33 bits so the window end cannot wrap.
  localparam logic [32:0] PcEnd = {1'b0, PC_RESET} + 33'(IM_WORDS) * 33'd4;

  fetch_state_e      state;
  fetch_state_e      stateNext;
  logic [31:0]       pc;
  logic [31:0]       pcNext;
  logic              bad;
  logic              pop;
  logic              pushOk;
  logic              push;
  fetch_entry_t      pushData;
  fetch_entry_t      headData;
  fetch_entry_t      lastHead;
  logic [CntW-1:0]   qCount;
  logic              qFull;
  logic              qEmpty;

  fetch_queue #(
    .DEPTH(FQ_DEPTH)
  ) u_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pushData (pushData),
    .pop      (pop),
    .flush    (redirect_valid),
    .headData (headData),
    .count    (qCount),
    .full     (qFull),
    .empty    (qEmpty)
  );

  // Range check, handshake qualification, next PC and state.
  always_comb begin
    bad       = (pc[1:0] != 2'b00) || (pc < PC_RESET) || ({1'b0, pc} >= PcEnd);
    f_valid   = (qCount != '0);
    pop       = f_valid && dec_ready;
    pushOk    = (state == FETCH_ST_RUN) && (!qFull || pop);
    push      = pushOk && !bad && !redirect_valid;
    pushData  = '{pc: pc, ins: im_ins};
    stateNext = state;
    pcNext    = pc;
    if (redirect_valid) begin
      pcNext    = redirect_pc;
      stateNext = FETCH_ST_RUN;
    end else if (state == FETCH_ST_RUN && bad) begin
      stateNext = FETCH_ST_ERR;
    end else if (push) begin
      pcNext = pc + 32'd4;
    end
  end

  // Fetch PC and controller state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc    <= PC_RESET;
      state <= FETCH_ST_RUN;
    end else begin
      pc    <= pcNext;
      state <= stateNext;
    end
  end

  // Remember the head so decode sees stable f_pc/f_ins while the queue is empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lastHead <= '0;
    end else if (!qEmpty) begin
      lastHead <= headData;
    end
  end

  // Output drive.
  always_comb begin
    im_pc = pc;
    f_err = (state == FETCH_ST_ERR);
    f_pc  = qEmpty ? lastHead.pc  : headData.pc;
    f_ins = qEmpty ? lastHead.ins : headData.ins;
  end

`ifdef FETCH_PERF_CNT_EN
  // Push and stall event counters, free-running with natural wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (push) perf_fetched <= perf_fetched + 32'd1;
      if (state == FETCH_ST_RUN && !pushOk && !redirect_valid) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Directed bench for im_fetch_ctrl. ROM model: word at address A reads {16'hABCD, A[15:0]}.
module tb_im_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] im_pc;
  logic [31:0] im_ins;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        f_valid;
  logic [31:0] f_pc;
  logic [31:0] f_ins;
  logic        f_err;
  logic        dec_ready;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  int nChecks = 0;
  int nFails  = 0;

  im_fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .im_pc          (im_pc),
    .im_ins         (im_ins),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .f_valid        (f_valid),
    .f_pc           (f_pc),
    .f_ins          (f_ins),
    .f_err          (f_err),
    .dec_ready      (dec_ready)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  assign im_ins = {16'hABCD, im_pc[15:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic redirectTo(input logic [31:0] target, input logic rdy);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    dec_ready      = rdy;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  initial begin
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    dec_ready      = 1'b1;
    @(negedge clk);
    checkEq("rst_f_valid", 32'(f_valid), 32'd0);
    checkEq("rst_f_err",   32'(f_err),   32'd0);
    checkEq("rst_f_pc",    f_pc,         32'h0);
    checkEq("rst_f_ins",   f_ins,        32'h0);
    checkEq("rst_im_pc",   im_pc,        32'h3000);
    reset = 1'b1;
    @(negedge clk);

    // Streaming with decode always ready.
    for (int i = 0; i < 4; i++) begin
      checkEq("stream_valid", 32'(f_valid), 32'd1);
      checkEq("stream_pc",    f_pc,  32'h3000 + 32'(4 * i));
      checkEq("stream_ins",   f_ins, 32'hABCD_3000 + 32'(4 * i));
      @(negedge clk);
    end

    // Back-pressure: queue fills after two pushes, pc holds.
    redirectTo(32'h3000, 1'b0);
    checkEq("bp_flushed", 32'(f_valid), 32'd0);
    checkEq("bp_im_pc0",  im_pc, 32'h3000);
    repeat (4) @(negedge clk);
    checkEq("bp_im_pc",   im_pc, 32'h3008);
    checkEq("bp_head",    f_pc,  32'h3000);
    checkEq("bp_valid",   32'(f_valid), 32'd1);
    dec_ready = 1'b1;
    checkEq("rel_pc0", f_pc, 32'h3000);
    @(negedge clk);
    checkEq("rel_pc1", f_pc, 32'h3004);
    @(negedge clk);
    checkEq("rel_pc2", f_pc, 32'h3008);
    checkEq("rel_ins2", f_ins, 32'hABCD_3008);

    // Redirect on a full queue with a pop: head consumed, rest dropped.
    redirectTo(32'h3040, 1'b1);
    checkEq("rd_valid", 32'(f_valid), 32'd0);
    checkEq("rd_hold",  f_pc,  32'h3008);
    checkEq("rd_im_pc", im_pc, 32'h3040);
    @(negedge clk);
    checkEq("rd_new_valid", 32'(f_valid), 32'd1);
    checkEq("rd_new_pc",    f_pc, 32'h3040);

    // Misaligned redirect traps one cycle later.
    redirectTo(32'h3002, 1'b1);
    checkEq("mis_err0",   32'(f_err),   32'd0);
    checkEq("mis_valid0", 32'(f_valid), 32'd0);
    @(negedge clk);
    checkEq("mis_err1",   32'(f_err),   32'd1);
    checkEq("mis_valid1", 32'(f_valid), 32'd0);
    checkEq("mis_im_pc",  im_pc, 32'h3002);
    repeat (2) @(negedge clk);
    checkEq("mis_err_hold", 32'(f_err),   32'd1);
    checkEq("mis_no_push",  32'(f_valid), 32'd0);
    redirectTo(32'h3000, 1'b1);
    checkEq("mis_clr", 32'(f_err), 32'd1 - 32'd1);
    @(negedge clk);
    checkEq("mis_resume_valid", 32'(f_valid), 32'd1);
    checkEq("mis_resume_pc",    f_pc, 32'h3000);

    // Running off the top of the ROM window.
    redirectTo(32'h6FF0, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checkEq("top_pc",  f_pc, 32'h6FF0 + 32'(4 * i));
      checkEq("top_err", 32'(f_err), 32'd0);
      @(negedge clk);
    end
    checkEq("top_valid_end", 32'(f_valid), 32'd0);
    checkEq("top_err_end",   32'(f_err),   32'd1);
    checkEq("top_last_pc",   f_pc,  32'h6FFC);
    checkEq("top_im_pc",     im_pc, 32'h7000);

    // Below the window.
    redirectTo(32'h2FFC, 1'b1);
    checkEq("low_err0", 32'(f_err), 32'd0);
    @(negedge clk);
    checkEq("low_err1", 32'(f_err), 32'd1);
    checkEq("low_valid", 32'(f_valid), 32'd0);

    // Trap with entries queued: they still drain.
    redirectTo(32'h6FF8, 1'b0);
    repeat (3) @(negedge clk);
    checkEq("drain_err",   32'(f_err),   32'd1);
    checkEq("drain_valid", 32'(f_valid), 32'd1);
    checkEq("drain_pc0",   f_pc, 32'h6FF8);
    dec_ready = 1'b1;
    @(negedge clk);
    checkEq("drain_pc1", f_pc, 32'h6FFC);
    checkEq("drain_v1",  32'(f_valid), 32'd1);
    @(negedge clk);
    checkEq("drain_empty", 32'(f_valid), 32'd0);

    // Asynchronous reset with a full queue.
    redirectTo(32'h3000, 1'b0);
    repeat (3) @(negedge clk);
    checkEq("ar_full_valid", 32'(f_valid), 32'd1);
    checkEq("ar_full_im_pc", im_pc, 32'h3008);
    #2;
    reset = 1'b0;
    #1;
    checkEq("ar_valid", 32'(f_valid), 32'd0);
    checkEq("ar_im_pc", im_pc, 32'h3000);
    checkEq("ar_err",   32'(f_err), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkEq("ar_after_valid", 32'(f_valid), 32'd1);
    checkEq("ar_after_pc",    f_pc,  32'h3000);
    checkEq("ar_after_im_pc", im_pc, 32'h3004);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
